// File: rtl/lcd_digit_writer_pkg.sv
// Shared definitions for the LCD digit writer: FSM state encodings, LCD command
// and ASCII constants, and the sizing helper for the timing counter.
package lcd_digit_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_ZERO        = 8'h30;
  localparam logic [3:0] BLANK_NIBBLE      = 4'hF;
  localparam logic [2:0] LAST_ITEM         = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_digit_writer_number_to_code.sv
// BCD nibble to LCD character code; any non-decimal nibble shows as a space.
module lcd_digit_writer_number_to_code
  import lcd_digit_writer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] code
);

  always_comb begin
    if (nibble <= 4'd9) begin
      code = ASCII_ZERO + {4'h0, nibble};
    end else begin
      code = ASCII_SPACE;
    end
  end

endmodule

// File: rtl/lcd_digit_writer.sv
// Writes a DDRAM address command followed by four BCD digits to a character LCD,
// with optional leading-zero blanking and parameterised E pulse/settle timing.
module lcd_digit_writer
  import lcd_digit_writer_pkg::*;
#(
  parameter int unsigned E_HIGH_CYC    = 20,
  parameter int unsigned CHAR_WAIT_CYC = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic [6:0]  addr,
  output logic        busy,
  output logic        done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  localparam int MAX_CYC = max_int(int'(E_HIGH_CYC), int'(CHAR_WAIT_CYC));
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  state_t          state, state_next;
  logic [2:0]      item, item_next;
  logic [CW-1:0]   cnt, cnt_next;

  logic [15:0]     dig_q;
  logic            blank_q;
  logic [6:0]      addr_q;

  logic [15:0]     sel_dig;
  logic            sel_blank;
  logic [6:0]      sel_addr;
  logic            blank0, blank1, blank2;
  logic [3:0]      raw_nib;
  logic            nib_blanked;
  logic [3:0]      conv_in;
  logic [7:0]      conv_code;
  logic [7:0]      data_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      item  <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      item  <= item_next;
      cnt   <= cnt_next;
    end
  end

  // Counter is loaded with (length-1) on entry to PULSE/WAIT and leaves at zero.
  always_comb begin
    state_next = state;
    item_next  = item;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
          item_next  = 3'd0;
        end
      end
      ST_SETUP: begin
        state_next = ST_PULSE;
        cnt_next   = CW'(E_HIGH_CYC - 1);
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_next = ST_WAIT;
          cnt_next   = CW'(CHAR_WAIT_CYC - 1);
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          if (item < LAST_ITEM) begin
            item_next  = item + 3'd1;
            state_next = ST_SETUP;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q   <= 16'h0000;
      blank_q <= 1'b0;
      addr_q  <= 7'h00;
    end else if (state == ST_IDLE && start) begin
      dig_q   <= digits;
      blank_q <= blank_lz;
      addr_q  <= addr;
    end
  end

  // Data for SETUP is registered on the edge that enters SETUP, so in IDLE the
  // incoming inputs are used directly instead of the not-yet-latched copies.
  always_comb begin
    sel_dig   = (state == ST_IDLE) ? digits   : dig_q;
    sel_blank = (state == ST_IDLE) ? blank_lz : blank_q;
    sel_addr  = (state == ST_IDLE) ? addr     : addr_q;
    blank0    = sel_blank && (sel_dig[15:12] == 4'h0);
    blank1    = blank0 && (sel_dig[11:8] == 4'h0);
    blank2    = blank1 && (sel_dig[7:4] == 4'h0);
    raw_nib     = 4'h0;
    nib_blanked = 1'b0;
    case (item_next)
      3'd1: begin raw_nib = sel_dig[15:12]; nib_blanked = blank0; end
      3'd2: begin raw_nib = sel_dig[11:8];  nib_blanked = blank1; end
      3'd3: begin raw_nib = sel_dig[7:4];   nib_blanked = blank2; end
      3'd4: begin raw_nib = sel_dig[3:0];   nib_blanked = 1'b0;   end
      default: begin raw_nib = 4'h0; nib_blanked = 1'b0; end
    endcase
    conv_in   = nib_blanked ? BLANK_NIBBLE : raw_nib;
    data_next = (item_next == 3'd0) ? (LCD_CMD_SET_DDRAM | {1'b0, sel_addr}) : conv_code;
  end

  lcd_digit_writer_number_to_code u_conv (
    .nibble (conv_in),
    .code   (conv_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      busy  <= (state_next != ST_IDLE);
      done  <= (state == ST_WAIT) && (state_next == ST_IDLE);
      lcd_e <= (state_next == ST_PULSE);
      if (state_next == ST_SETUP) begin
        lcd_rs   <= (item_next != 3'd0);
        lcd_data <= data_next;
      end
    end
  end

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Directed, table-driven bench for lcd_digit_writer with short timing
// (E high 2 cycles, settle 3 cycles -> 6 cycles per item, 30 per transaction).
module tb_lcd_digit_writer;

  typedef struct {
    logic [15:0]     digits;
    logic            blank;
    logic [6:0]      addr;
    logic [7:0]      exp [5];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic        blankLz = 1'b0;
  logic [6:0]  addr = 7'h00;
  logic        busy, done, lcdE, lcdRs, lcdRw;
  logic [7:0]  lcdData;

  int checks = 0;
  int errors = 0;
  int rwErrors = 0;
  logic [8:0] cap [$];
  vec_t vecs [8];

  lcd_digit_writer #(.E_HIGH_CYC(2), .CHAR_WAIT_CYC(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .digits   (digits),
    .blank_lz (blankLz),
    .addr     (addr),
    .busy     (busy),
    .done     (done),
    .lcd_e    (lcdE),
    .lcd_rs   (lcdRs),
    .lcd_rw   (lcdRw),
    .lcd_data (lcdData)
  );

  always #5 clk = ~clk;

  always @(posedge lcdE) cap.push_back({lcdRs, lcdData});

  always @(negedge clk) if (lcdRw !== 1'b0) rwErrors++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts one transaction, optionally pokes START with other digits mid-way,
  // and returns the number of edges from acceptance to the DONE cycle.
  task automatic applyStimulus(input logic [15:0] d, input logic b, input logic [6:0] a,
                               input int pokeAt, output int cyc);
    cap.delete();
    @(negedge clk);
    digits = d; blankLz = b; addr = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start = (pokeAt == cyc);
      if (pokeAt == cyc) digits = 16'h9999;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic checkCapture(input string name, input logic [6:0] a, input logic [7:0] exp [5]);
    logic [8:0] got;
    checkOutput({name, " pulses"}, cap.size(), 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < cap.size()) ? cap[i] : 9'h1FF;
      if (i == 0) checkOutput($sformatf("%s cmd", name), got, {1'b0, 8'h80 | {1'b0, a}});
      else        checkOutput($sformatf("%s char%0d", name, i), got, {1'b1, exp[i]});
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'h1234, 1'b0, 7'h40, '{8'h00, 8'h31, 8'h32, 8'h33, 8'h34}};
    vecs[1] = '{16'h0070, 1'b1, 7'h00, '{8'h00, 8'h20, 8'h20, 8'h37, 8'h30}};
    vecs[2] = '{16'h0000, 1'b1, 7'h05, '{8'h00, 8'h20, 8'h20, 8'h20, 8'h30}};
    vecs[3] = '{16'h0A05, 1'b0, 7'h7F, '{8'h00, 8'h30, 8'h20, 8'h30, 8'h35}};
    vecs[4] = '{16'h0070, 1'b0, 7'h10, '{8'h00, 8'h30, 8'h30, 8'h37, 8'h30}};
    vecs[5] = '{16'h0105, 1'b1, 7'h20, '{8'h00, 8'h20, 8'h31, 8'h30, 8'h35}};
    vecs[6] = '{16'h9B00, 1'b1, 7'h00, '{8'h00, 8'h39, 8'h20, 8'h30, 8'h30}};
    vecs[7] = '{16'hF000, 1'b1, 7'h33, '{8'h00, 8'h20, 8'h30, 8'h30, 8'h30}};

    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset lcd_e", lcdE, 0);
    checkOutput("reset lcd_rs", lcdRs, 0);
    checkOutput("reset lcd_data", lcdData, 8'h00);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].digits, vecs[v].blank, vecs[v].addr, 0, cyc);
      checkOutput($sformatf("vec%0d latency", v), cyc, 30);
      checkOutput($sformatf("vec%0d busy at done", v), busy, 0);
      checkCapture($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp);
    end

    // START pulsed with other digits while busy must be ignored, one DONE only
    applyStimulus(16'h1234, 1'b0, 7'h40, 9, cyc);
    checkOutput("ignore latency", cyc, 30);
    checkCapture("ignore", 7'h40, vecs[0].exp);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) cyc++;
    end
    checkOutput("ignore extra activity", cyc, 0);

    // Asynchronous reset in item 2's PULSE, then a clean restart
    cap.delete();
    @(negedge clk);
    digits = 16'h1234; blankLz = 1'b0; addr = 7'h40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    checkOutput("pre-abort lcd_e", lcdE, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort lcd_e", lcdE, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort lcd_data", lcdData, 8'h00);
    checkOutput("abort lcd_rs", lcdRs, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-abort idle", busy, 0);
    applyStimulus(16'h1234, 1'b0, 7'h40, 0, cyc);
    checkOutput("restart latency", cyc, 30);
    checkCapture("restart", 7'h40, vecs[0].exp);

    // START held high: next SETUP follows the DONE cycle directly
    @(negedge clk);
    digits = 16'h1234; blankLz = 1'b0; addr = 7'h40; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (done) break;
    end
    checkOutput("cont first latency", cyc, 30);
    cap.delete();
    @(posedge clk); #1;
    checkOutput("cont setup busy", busy, 1);
    checkOutput("cont setup lcd_e", lcdE, 0);
    checkOutput("cont setup cmd", {lcdRs, lcdData}, {1'b0, 8'hC0});
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (done) break;
    end
    start = 1'b0;
    checkOutput("cont second latency", cyc, 30);
    checkCapture("cont", 7'h40, vecs[0].exp);
    checkOutput("lcd_rw always low", rwErrors, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_digit_writer.md
LCD_DIGIT_WRITER -- requirements
Module: lcd_digit_writer

Interface
REQ-001 Parameter E_HIGH_CYC, default 20: LCD_E high width in CLK cycles, minimum 1.
REQ-002 Parameter CHAR_WAIT_CYC, default 2000: LCD_E low settle time after each pulse in CLK cycles, minimum 1.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  request to write one 4-digit field; sampled only in IDLE.
REQ-006 DIGITS  input  16  four BCD nibbles; [15:12] is the most significant digit and is written first.
REQ-007 BLANK_LZ  input  1  leading-zero blanking enable; latched with START.
REQ-008 ADDR  input  7  LCD DDRAM start address; latched with START.
REQ-009 BUSY  output  1  high while a transaction is in progress.
REQ-010 DONE  output  1  one-cycle pulse when a transaction completes.
REQ-011 LCD_E, LCD_RS, LCD_RW  output  1 each  character-LCD strobe, register select and read/write lines.
REQ-012 LCD_DATA  output  8  character-LCD data bus.

Function
REQ-013 States SHALL be IDLE, SETUP, PULSE, WAIT; a 3-bit item index (0..4) selects the current item.
REQ-014 IDLE transitions to SETUP on START=1, latching DIGITS, BLANK_LZ and ADDR and clearing the item index to 0.
REQ-015 START SHALL be ignored outside IDLE, and latched values SHALL NOT change while BUSY=1.
REQ-016 Item 0 is the address command: LCD_RS=0, LCD_DATA=8'h80|ADDR.
REQ-017 Items 1..4 are characters: LCD_RS=1, LCD_DATA=ASCII code of latched digit (item-1), counted from the MSB.
REQ-018 Digit to ASCII mapping: 0..9 -> 8'h30..8'h39; any nibble above 9 -> 8'h20 (space).
REQ-019 Blanking: with BLANK_LZ=1, every zero digit before the first nonzero digit among digits 0..2 is replaced by 8'h20.
REQ-020 Digit 3 (the least significant digit) SHALL never be blanked, so 0000 displays as "   0".
REQ-021 SETUP lasts 1 cycle: LCD_RS and LCD_DATA are valid and LCD_E=0.
REQ-022 PULSE lasts E_HIGH_CYC cycles with LCD_E=1; LCD_RS and LCD_DATA are held stable.
REQ-023 WAIT lasts CHAR_WAIT_CYC cycles with LCD_E=0; LCD_RS and LCD_DATA are held stable.
REQ-024 At the end of WAIT: if item<4, increment the item index and go to SETUP; otherwise go to IDLE.
REQ-025 Each item takes 1+E_HIGH_CYC+CHAR_WAIT_CYC cycles; a full transaction takes 5 times that.
REQ-026 BUSY SHALL be registered and equal to (state != IDLE).
REQ-027 DONE SHALL be 1 only in the first IDLE cycle after item 4's WAIT; BUSY is 0 in that cycle.
REQ-028 A START in the DONE cycle SHALL be accepted, giving back-to-back transactions with no idle gap beyond that cycle.
REQ-029 LCD_RW SHALL be constant 0 (write only).
REQ-030 LCD_E SHALL be a registered output with no glitches.

Reset
REQ-031 RST=1 SHALL immediately force state IDLE and item index 0.
REQ-032 RST=1 SHALL immediately force BUSY=0, DONE=0, LCD_E=0, LCD_RS=0, LCD_RW=0 and LCD_DATA=8'h00.
REQ-033 Reset during any state SHALL abort the transaction; no partial resume occurs.
REQ-034 The next START after reset SHALL begin again at item 0.

Structure
REQ-035 A shared defines file SHALL hold the state encodings, LCD_CMD_SET_DDRAM (8'h80) and ASCII_SPACE (8'h20).
REQ-036 The block SHALL instantiate the existing Number_to_code converter once, fed by a mux of the latched digits.
REQ-037 Blanked digits SHALL be forced to nibble 4'hF before the converter, which maps them to 8'h20.
REQ-038 No other sub-modules SHALL be used; the timing counter SHALL be sized for max(E_HIGH_CYC, CHAR_WAIT_CYC).

Verification (E_HIGH_CYC=2, CHAR_WAIT_CYC=3, so 6 cycles per item and 30 per transaction)
REQ-039 Basic write: DIGITS=16'h1234, BLANK_LZ=0, ADDR=7'h40 -> five E pulses carrying C0(RS=0), 31, 32, 33, 34(RS=1); DONE exactly 30 cycles after START acceptance.
REQ-040 Blanking: DIGITS=16'h0070, BLANK_LZ=1 -> characters 20, 20, 37, 30; DIGITS=16'h0000, BLANK_LZ=1 -> 20, 20, 20, 30.
REQ-041 Invalid nibble: DIGITS=16'h0A05, BLANK_LZ=0 -> characters 30, 20, 30, 35.
REQ-042 Ignored START: pulse START with DIGITS=16'h9999 while BUSY during a 16'h1234 write -> output sequence unchanged, and only one DONE.
REQ-043 Mid-transaction reset: RST pulsed during item 2's PULSE -> LCD_E and BUSY drop asynchronously; the next START produces the full sequence starting with the address command.
REQ-044 Continuous START: START held at 1 -> consecutive transactions, each new SETUP in the cycle after DONE, and LCD_RW=0 throughout.
